// File: rtl/y86_mem_pkg.sv
// Shared Y86 memory definitions: word width, responder FSM encoding, memory-stage icodes.
// Latency: none (declarations and pure helper functions only).
// Backpressure: not applicable.
package y86_mem_pkg;

  localparam int WORD_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  // Instructions whose memory stage reads data memory.
  function automatic logic icode_mem_read(input logic [3:0] icode);
    return (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ) || (icode == ICODE_RET);
  endfunction

  // Instructions whose memory stage writes data memory.
  function automatic logic icode_mem_write(input logic [3:0] icode);
    return (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port DEPTH x 64 synchronous RAM with write enable and registered read data.
// Latency: read data valid one cycle after an enabled read; writes land on the enabled edge.
// Backpressure: none; rdata holds its value until the next enabled read. No reset.
module dmem_array
  import y86_mem_pkg::*;
#(
  parameter int DEPTH = 201,
  parameter int AW    = 8
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] rdata_q;

  // Enabled write stores the word; enabled read captures the pre-edge contents.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_memory.sv
// Y86 data-memory responder: one load/store at a time, range-checked, optional stats (DMEM_STATS_EN).
// Latency: resp_valid rises LATENCY+1 cycles after the accept edge; one transaction per LATENCY+2 cycles at best.
// Backpressure: req_ready only in IDLE; response held stable until resp_ready.
module data_memory
  import y86_mem_pkg::*;
#(
  parameter int DEPTH   = 201,
  parameter int LATENCY = 2,
  parameter int CNT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err,
  output logic              resp_we
`ifdef DMEM_STATS_EN
  ,
  output logic [CNT_W-1:0]  stat_reads,
  output logic [CNT_W-1:0]  stat_writes,
  output logic [CNT_W-1:0]  stat_errors
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // The wait counter only ever holds LATENCY-1 down to 0.
  localparam int CW = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam logic [WORD_W-1:0] MAX_ADDR = WORD_W'(DEPTH - 1);
  localparam logic [CW-1:0]     CNT_LOAD = (LATENCY > 0) ? CW'(LATENCY - 1) : '0;

  dmem_state_t       state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              req_ready_q, req_ready_d;
  logic              resp_valid_q, resp_valid_d;
  logic              resp_err_q, resp_err_d;
  logic              resp_we_q, resp_we_d;
  logic              rd_ok_q, rd_ok_d;

  logic              c_we;
  logic [WORD_W-1:0] c_addr;
  logic [WORD_W-1:0] c_wdata;
  logic              addr_ok;
  logic              commit;
  logic              ram_en;
  logic [WORD_W-1:0] ram_rdata;

  // With zero latency the access commits on the accept edge, so it is taken straight
  // from the request; otherwise it comes from the request latch.
  always_comb begin
    c_we    = we_q;
    c_addr  = addr_q;
    c_wdata = wdata_q;
    if (state_q == IDLE) begin
      c_we    = req_we;
      c_addr  = req_addr;
      c_wdata = req_wdata;
    end
  end

  // Full 64-bit compare: any set upper bit is out of range, never wrapped.
  assign addr_ok = (c_addr <= MAX_ADDR);
  assign commit  = ((state_q == IDLE) && req_valid && (LATENCY == 0)) ||
                   ((state_q == WAIT) && (cnt_q == '0));
  // A reset on the commit edge drops the access, so a store in flight never lands.
  assign ram_en  = commit && addr_ok && !rst;

  dmem_array #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (c_we),
    .addr  (c_addr[AW-1:0]),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  // Next-state for the FSM, request latch, wait counter and response flags.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    resp_we_d    = resp_we_q;
    rd_ok_d      = rd_ok_q;
    unique case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          if (LATENCY == 0) begin
            state_d = RESP;
          end else begin
            cnt_d   = CNT_LOAD;
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (resp_ready) begin
          state_d      = IDLE;
          resp_valid_d = 1'b0;
          resp_err_d   = 1'b0;
          resp_we_d    = 1'b0;
          rd_ok_d      = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (commit) begin
      resp_valid_d = 1'b1;
      resp_err_d   = !addr_ok;
      resp_we_d    = c_we;
      rd_ok_d      = addr_ok && !c_we;
    end
  end

  assign req_ready_d = (state_d == IDLE);

  // FSM state and registered outputs; synchronous reset leaves the array untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_we_q    <= 1'b0;
      rd_ok_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      resp_we_q    <= resp_we_d;
      rd_ok_q      <= rd_ok_d;
    end
  end

  assign req_ready  = req_ready_q;
  assign resp_valid = resp_valid_q;
  assign resp_err   = resp_err_q;
  assign resp_we    = resp_we_q;
  // The RAM read register holds its value through RESP; stores and errors read as zero.
  assign resp_rdata = rd_ok_q ? ram_rdata : '0;

`ifdef DMEM_STATS_EN
  logic [CNT_W-1:0] rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0] wr_cnt_q, wr_cnt_d;
  logic [CNT_W-1:0] er_cnt_q, er_cnt_d;
  logic             resp_fire;

  assign resp_fire = resp_valid_q && resp_ready;

  // Each response handshake bumps exactly one saturating counter, by response kind.
  always_comb begin
    rd_cnt_d = rd_cnt_q;
    wr_cnt_d = wr_cnt_q;
    er_cnt_d = er_cnt_q;
    if (resp_fire) begin
      if (resp_err_q) begin
        er_cnt_d = (&er_cnt_q) ? er_cnt_q : er_cnt_q + 1'b1;
      end else if (resp_we_q) begin
        wr_cnt_d = (&wr_cnt_q) ? wr_cnt_q : wr_cnt_q + 1'b1;
      end else begin
        rd_cnt_d = (&rd_cnt_q) ? rd_cnt_q : rd_cnt_q + 1'b1;
      end
    end
  end

  // Statistics registers, cleared by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
      er_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
      wr_cnt_q <= wr_cnt_d;
      er_cnt_q <= er_cnt_d;
    end
  end

  assign stat_reads  = rd_cnt_q;
  assign stat_writes = wr_cnt_q;
  assign stat_errors = er_cnt_q;
`endif

endmodule

// File: tb/tb_data_memory.sv
// Bench for data_memory: randomized load/store traffic against a behavioural model,
// plus directed literal checks (latency, range errors, held response, reset in WAIT,
// zero-latency back-to-back on a second instance, and stats when DMEM_STATS_EN is set).
`timescale 1ns/1ps
module tb_data_memory;

  localparam int DEPTH = 201;
  localparam int LAT   = 2;
  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, req_we;
  logic [63:0] req_addr, req_wdata;
  logic        resp_valid, resp_ready, resp_err, resp_we;
  logic [63:0] resp_rdata;

  logic        z_req_valid, z_req_ready, z_req_we;
  logic [63:0] z_req_addr, z_req_wdata;
  logic        z_resp_valid, z_resp_ready, z_resp_err, z_resp_we;
  logic [63:0] z_resp_rdata;

`ifdef DMEM_STATS_EN
  logic [CNT_W-1:0] stat_reads, stat_writes, stat_errors;
  logic [CNT_W-1:0] z_stat_reads, z_stat_writes, z_stat_errors;
`endif

  data_memory #(.DEPTH(DEPTH), .LATENCY(LAT), .CNT_W(CNT_W)) u_dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .resp_err(resp_err), .resp_we(resp_we)
`ifdef DMEM_STATS_EN
    , .stat_reads(stat_reads), .stat_writes(stat_writes), .stat_errors(stat_errors)
`endif
  );

  data_memory #(.DEPTH(DEPTH), .LATENCY(0), .CNT_W(CNT_W)) u_dut0 (
    .clk(clk), .rst(rst),
    .req_valid(z_req_valid), .req_ready(z_req_ready), .req_we(z_req_we),
    .req_addr(z_req_addr), .req_wdata(z_req_wdata),
    .resp_valid(z_resp_valid), .resp_ready(z_resp_ready), .resp_rdata(z_resp_rdata),
    .resp_err(z_resp_err), .resp_we(z_resp_we)
`ifdef DMEM_STATS_EN
    , .stat_reads(z_stat_reads), .stat_writes(z_stat_writes), .stat_errors(z_stat_errors)
`endif
  );

  int n_cmp = 0;
  int n_bad = 0;

  // ---------------- behavioural model of u_dut ----------------
  logic [63:0]      mem_m [DEPTH];
  bit               pending = 1'b0, committed = 1'b0, lat_seen = 1'b0;
  int               acc_e = 0, edge_n = 0, hs_count = 0, cap_lat = 0;
  bit               m_we, m_err;
  logic [63:0]      m_addr, m_wdata, m_rdata;
  logic [CNT_W-1:0] m_reads = '0, m_writes = '0, m_errors = '0;
  logic [63:0]      cap_rdata;
  logic             cap_err, cap_we;
  bit               rand_rdy = 1'b0;

  function automatic logic [63:0] pat(input int a);
    return {32'hA5A5_5A5A, a[31:0]};
  endfunction

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out waiting (edge %0d)", name, edge_n);
  endtask

  // Model: one outstanding access; commit LAT edges after accept; handshake after that.
  initial forever begin
    @(posedge clk);
    if (rst) begin
      pending  = 1'b0;
      m_reads  = '0;
      m_writes = '0;
      m_errors = '0;
    end else begin
      if (pending && !committed && edge_n == acc_e + LAT) begin
        if (m_we && !m_err) mem_m[int'(m_addr)] = m_wdata;
        committed = 1'b1;
      end
      if (pending && edge_n > acc_e + LAT && resp_ready) begin
        pending   = 1'b0;
        cap_rdata = resp_rdata;
        cap_err   = resp_err;
        cap_we    = resp_we;
        if (m_err) m_errors++;
        else if (m_we) m_writes++;
        else m_reads++;
        hs_count++;
      end else if (!pending && req_valid) begin
        pending   = 1'b1;
        committed = 1'b0;
        lat_seen  = 1'b0;
        acc_e     = edge_n;
        m_we      = req_we;
        m_addr    = req_addr;
        m_wdata   = req_wdata;
        m_err     = (req_addr > 64'(DEPTH - 1));
        m_rdata   = (m_err || m_we) ? 64'd0 : mem_m[int'(req_addr)];
        if (LAT == 0) begin
          if (m_we && !m_err) mem_m[int'(m_addr)] = m_wdata;
          committed = 1'b1;
        end
      end
    end
    edge_n++;
  end

  // Compare process: every cycle out of reset, DUT outputs against the model.
  initial forever begin
    bit ev;
    @(negedge clk);
    if (!rst) begin
      ev = pending && ((edge_n - 1) >= acc_e + LAT);
      chk1("req_ready", req_ready, !pending);
      chk1("resp_valid", resp_valid, ev);
      if (ev && resp_valid === 1'b1) begin
        if (!lat_seen) begin
          cap_lat  = edge_n - acc_e;
          lat_seen = 1'b1;
        end
        chk64("resp_rdata", resp_rdata, m_rdata);
        chk1("resp_err", resp_err, m_err);
        chk1("resp_we", resp_we, m_we);
      end
`ifdef DMEM_STATS_EN
      chk64("stat_reads", 64'(stat_reads), 64'(m_reads));
      chk64("stat_writes", 64'(stat_writes), 64'(m_writes));
      chk64("stat_errors", 64'(stat_errors), 64'(m_errors));
`endif
    end
  end

  // Random response backpressure while enabled.
  initial forever begin
    @(negedge clk);
    if (rand_rdy) resp_ready = ($urandom_range(0, 3) != 0);
  end

  // Present one request, hold it until accepted; optionally wait for its handshake.
  task automatic txn(input bit we, input logic [63:0] addr, input logic [63:0] wd, input bit wait_hs);
    int g;
    int hs0;
    g = 0;
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wd;
    while (req_ready !== 1'b1 && g < 50) begin @(negedge clk); g++; end
    if (g >= 50) timeout("accept");
    @(negedge clk);
    req_valid = 1'b0;
    hs0 = hs_count;
    if (wait_hs) begin
      g = 0;
      while (hs_count == hs0 && g < 200) begin @(negedge clk); g++; end
      if (g >= 200) timeout("handshake");
    end
  endtask

  task automatic wait_idle();
    int g;
    g = 0;
    while (pending && g < 300) begin @(negedge clk); g++; end
    if (g >= 300) timeout("drain");
  endtask

  task automatic chk_reset(input string tag);
    chk1({tag, "_req_ready"}, req_ready, 1'b1);
    chk1({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk64({tag, "_resp_rdata"}, resp_rdata, 64'd0);
    chk1({tag, "_resp_err"}, resp_err, 1'b0);
    chk1({tag, "_resp_we"}, resp_we, 1'b0);
  endtask

  // Drive one request into the zero-latency instance; report accept edge and next-cycle response.
  task automatic z_issue(input bit we, input logic [63:0] a, input logic [63:0] d,
                         output int acc, output logic v1, output logic [63:0] rd);
    int g;
    g = 0;
    z_req_valid = 1'b1; z_req_we = we; z_req_addr = a; z_req_wdata = d;
    while (z_req_ready !== 1'b1 && g < 20) begin @(negedge clk); g++; end
    if (g >= 20) timeout("z_accept");
    acc = edge_n;
    @(negedge clk);
    z_req_valid = 1'b0;
    v1 = z_resp_valid;
    rd = z_resp_rdata;
  endtask

  initial begin
    int          a0, a1;
    logic        v;
    logic [63:0] rd;
    int          r;
    logic [63:0] ad;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    z_req_valid = 1'b0; z_req_we = 1'b0; z_req_addr = '0; z_req_wdata = '0; z_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_reset("reset");

    // Preload every word so loads have known contents.
    rand_rdy = 1'b1;
    for (int a = 0; a < DEPTH; a++) txn(1'b1, 64'(a), pat(a), 1'b0);
    wait_idle();

    // Store/load round trip and accept-to-valid latency.
    rand_rdy = 1'b0; resp_ready = 1'b1;
    txn(1'b1, 64'd5, 64'hDEAD_BEEF, 1'b1);
    chk64("t1_store_latency", 64'(cap_lat), 64'd3);
    chk1("t1_store_err", cap_err, 1'b0);
    chk1("t1_store_we", cap_we, 1'b1);
    txn(1'b0, 64'd5, 64'd0, 1'b1);
    chk64("t1_load_data", cap_rdata, 64'hDEAD_BEEF);
    chk1("t1_load_we", cap_we, 1'b0);

    // Range boundaries.
    txn(1'b0, 64'd200, 64'd0, 1'b1);
    chk64("t2_last_word", cap_rdata, 64'hA5A5_5A5A_0000_00C8);
    chk1("t2_last_err", cap_err, 1'b0);
    txn(1'b0, 64'd201, 64'd0, 1'b1);
    chk1("t2_depth_err", cap_err, 1'b1);
    chk64("t2_depth_rdata", cap_rdata, 64'd0);
    txn(1'b1, 64'h1_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1);
    chk1("t2_high_err", cap_err, 1'b1);
    txn(1'b0, 64'd0, 64'd0, 1'b1);
    chk64("t2_mem0_kept", cap_rdata, 64'hA5A5_5A5A_0000_0000);

    // Response held under backpressure.
    resp_ready = 1'b0;
    txn(1'b0, 64'd9, 64'd0, 1'b0);
    r = 0;
    while (resp_valid !== 1'b1 && r < 20) begin @(negedge clk); r++; end
    if (r >= 20) timeout("t3_valid");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk1("t3_hold_valid", resp_valid, 1'b1);
      chk64("t3_hold_rdata", resp_rdata, 64'hA5A5_5A5A_0000_0009);
      chk1("t3_hold_req_ready", req_ready, 1'b0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    chk1("t3_release_req_ready", req_ready, 1'b1);
    chk1("t3_release_valid", resp_valid, 1'b0);

    // Reset in WAIT drops the store.
    txn(1'b1, 64'd7, 64'h11, 1'b1);
    txn(1'b1, 64'd7, 64'h99, 1'b0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_reset("t4");
    txn(1'b0, 64'd7, 64'd0, 1'b1);
    chk64("t4_store_dropped", cap_rdata, 64'h11);

    // Zero-latency instance: response one cycle after accept, accepts two cycles apart.
    z_issue(1'b1, 64'd0, 64'h100, a0, v, rd);
    chk1("t5_store_valid", v, 1'b1);
    chk1("t5_store_we", z_resp_we, 1'b1);
    @(negedge clk);
    z_issue(1'b1, 64'd1, 64'h101, a0, v, rd);
    @(negedge clk);
    z_issue(1'b0, 64'd0, 64'd0, a0, v, rd);
    chk1("t5_load0_valid", v, 1'b1);
    chk64("t5_load0_data", rd, 64'h100);
    z_issue(1'b0, 64'd1, 64'd0, a1, v, rd);
    chk1("t5_load1_valid", v, 1'b1);
    chk64("t5_load1_data", rd, 64'h101);
    chk1("t5_load1_err", z_resp_err, 1'b0);
    chk64("t5_accept_gap", 64'(a1 - a0), 64'd2);
    @(negedge clk);

`ifdef DMEM_STATS_EN
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    txn(1'b0, 64'd1, 64'd0, 1'b1);
    txn(1'b0, 64'd2, 64'd0, 1'b1);
    txn(1'b1, 64'd4, pat(4), 1'b1);
    txn(1'b0, 64'd3, 64'd0, 1'b1);
    txn(1'b0, 64'd999, 64'd0, 1'b1);
    txn(1'b1, 64'd6, pat(6), 1'b1);
    chk64("t6_reads", 64'(stat_reads), 64'd3);
    chk64("t6_writes", 64'(stat_writes), 64'd2);
    chk64("t6_errors", 64'(stat_errors), 64'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk64("t6_reads_rst", 64'(stat_reads), 64'd0);
    chk64("t6_writes_rst", 64'(stat_writes), 64'd0);
    chk64("t6_errors_rst", 64'(stat_errors), 64'd0);
`endif

    // Randomized traffic against the model.
    rand_rdy = 1'b1;
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      if (r <= 6)      ad = 64'($urandom_range(0, DEPTH - 1));
      else if (r == 7) ad = ($urandom_range(0, 1) != 0) ? 64'(DEPTH) : 64'(DEPTH - 1);
      else if (r == 8) ad = {$urandom, $urandom};
      else             ad = 64'd1 << $urandom_range(8, 63);
      txn(1'($urandom_range(0, 1)), ad, {$urandom, $urandom}, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    resp_ready = 1'b1;
    rand_rdy = 1'b0;
    wait_idle();
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
